// File: rtl/alu4.sv
// alu4: registered WIDTH-bit integer ALU with carry/borrow, zero and
// signed-overflow flags. One cycle from input sample to output.
module alu4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUctr,
    output logic [WIDTH-1:0] F,
    output logic             cf,
    output logic             zero,
    output logic             of
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_SUB  = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOR  = 3'b101,
        OP_SLT  = 3'b110,
        OP_SLTU = 3'b111
    } op_e;

    // Shared adder/subtractor signals.
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             carry_out;
    logic             ovf;
    logic             lt_signed;
    logic             lt_unsigned;

    // Next-state values for the output registers.
    logic [WIDTH-1:0] f_d,    f_q;
    logic             cf_d,   cf_q;
    logic             zero_d, zero_q;
    logic             of_d,   of_q;

    // One adder serves ADD, SUB, SLT and SLTU; everything but ADD subtracts.
    always_comb begin
        is_sub      = (ALUctr != OP_ADD);
        b_eff       = is_sub ? ~B : B;
        sum         = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        carry_out   = sum[WIDTH];
        // Operands of the adder share a sign but the result does not.
        ovf         = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        lt_signed   = sum[WIDTH-1] ^ ovf;
        lt_unsigned = ~carry_out;
    end

    // Select the result and flags for the requested operation.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would infer a latch.
        f_d  = '0;
        cf_d = 1'b0;
        of_d = 1'b0;
        case (ALUctr)
            OP_ADD: begin
                f_d  = sum[WIDTH-1:0];
                cf_d = carry_out;
                of_d = ovf;
            end
            OP_SUB: begin
                f_d  = sum[WIDTH-1:0];
                cf_d = ~carry_out;
                of_d = ovf;
            end
            OP_AND:  f_d = A & B;
            OP_OR:   f_d = A | B;
            OP_XOR:  f_d = A ^ B;
            OP_NOR:  f_d = ~(A | B);
            OP_SLT:  f_d = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: f_d = {{(WIDTH-1){1'b0}}, lt_unsigned};
            default: f_d = '0;
        endcase
        zero_d = (f_d == '0);
    end

    // Output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            f_q    <= '0;
            cf_q   <= 1'b0;
            zero_q <= 1'b1;
            of_q   <= 1'b0;
        end else begin
            f_q    <= f_d;
            cf_q   <= cf_d;
            zero_q <= zero_d;
            of_q   <= of_d;
        end
    end

    assign F    = f_q;
    assign cf   = cf_q;
    assign zero = zero_q;
    assign of   = of_q;

endmodule

// File: tb/tb_alu4.sv
// tb_alu4: directed and random checks of alu4 with a scoreboard queue.
module tb_alu4;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] f;
        logic         cf;
        logic         zero;
        logic         of;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [2:0]   ALUctr;
    logic [W-1:0] F;
    logic         cf;
    logic         zero;
    logic         of;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    alu4 #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .ALUctr (ALUctr),
        .F      (F),
        .cf     (cf),
        .zero   (zero),
        .of     (of)
    );

    always #5 clk = ~clk;

    // Reference model written with plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op);
        exp_t e;
        int   ua, ub, sa, sb, r, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        e  = '0;
        case (op)
            3'b000: begin
                r    = ua + ub;
                sr   = sa + sb;
                e.f  = r[W-1:0];
                e.cf = (r > 15);
                e.of = (sr > 7) || (sr < -8);
            end
            3'b011: begin
                r    = ua - ub;
                sr   = sa - sb;
                e.f  = r[W-1:0];
                e.cf = (ua < ub);
                e.of = (sr > 7) || (sr < -8);
            end
            3'b001: e.f = a & b;
            3'b010: e.f = a | b;
            3'b100: e.f = a ^ b;
            3'b101: e.f = ~(a | b);
            3'b110: e.f = (sa < sb) ? 4'd1 : 4'd0;
            default: e.f = (ua < ub) ? 4'd1 : 4'd0;
        endcase
        e.zero = (e.f == '0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] f, input logic c,
                                input logic z, input logic o);
        exp_t e;
        e.f    = f;
        e.cf   = c;
        e.zero = z;
        e.of   = o;
        return e;
    endfunction

    task automatic compare(input exp_t e, input string tag);
        exp_t obs;
        obs = {F, cf, zero, of};
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: got F=%b cf=%b zero=%b of=%b, want F=%b cf=%b zero=%b of=%b",
                   tag, obs.f, obs.cf, obs.zero, obs.of, e.f, e.cf, e.zero, e.of);
        end
    endtask

    // Drive one vector, expect its result one edge later, then confirm that
    // wiggling the inputs between edges leaves the outputs untouched.
    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input exp_t e, input string tag);
        exp_t got_e;
        @(negedge clk);
        rst    = r;
        A      = a;
        B      = b;
        ALUctr = op;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty, got F=%b want an entry", tag, F);
        end else begin
            got_e = sb_q.pop_front();
            compare(got_e, tag);
            A      = ~a;
            B      = a ^ b;
            ALUctr = op + 3'd3;
            #1;
            compare(got_e, {tag, "_hold"});
        end
    endtask

    task automatic step_m(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input string tag);
        step(1'b0, a, b, op, model(a, b, op), tag);
    endtask

    initial begin
        rst    = 1'b1;
        A      = '0;
        B      = '0;
        ALUctr = '0;

        // Reset, then the held inputs produce a normal ADD result.
        step(1'b1, 4'b0101, 4'b0011, 3'b000, mk(4'b0000, 0, 1, 0), "reset");
        step(1'b0, 4'b0101, 4'b0011, 3'b000, mk(4'b1000, 0, 0, 1), "post_reset_add");

        // SUB borrow / overflow sweep.
        step(1'b0, 4'b0000, 4'b0111, 3'b011, mk(4'b1001, 1, 0, 0), "sub_0_7");
        step(1'b0, 4'b1111, 4'b1000, 3'b011, mk(4'b0111, 0, 0, 0), "sub_f_8");
        step(1'b0, 4'b1000, 4'b0111, 3'b011, mk(4'b0001, 0, 0, 1), "sub_8_7");
        step(1'b0, 4'b0111, 4'b1000, 3'b011, mk(4'b1111, 1, 0, 1), "sub_7_8");
        step(1'b0, 4'b0000, 4'b1000, 3'b011, mk(4'b1000, 1, 0, 1), "sub_0_8");
        step(1'b0, 4'b0101, 4'b1010, 3'b011, mk(4'b1011, 1, 0, 1), "sub_5_a");

        // SUB equality and zero flag.
        step(1'b0, 4'b1000, 4'b1000, 3'b011, mk(4'b0000, 0, 1, 0), "sub_eq_8");
        step(1'b0, 4'b0011, 4'b0011, 3'b011, mk(4'b0000, 0, 1, 0), "sub_eq_3");
        step(1'b0, 4'b0011, 4'b0001, 3'b011, mk(4'b0010, 0, 0, 0), "sub_3_1");

        // ADD carry / overflow.
        step(1'b0, 4'b1111, 4'b0001, 3'b000, mk(4'b0000, 1, 1, 0), "add_f_1");
        step(1'b0, 4'b0111, 4'b0001, 3'b000, mk(4'b1000, 0, 0, 1), "add_7_1");
        step(1'b0, 4'b1000, 4'b1000, 3'b000, mk(4'b0000, 1, 1, 1), "add_8_8");

        // Logic operations.
        step(1'b0, 4'b0101, 4'b1010, 3'b001, mk(4'b0000, 0, 1, 0), "and");
        step(1'b0, 4'b0101, 4'b1010, 3'b010, mk(4'b1111, 0, 0, 0), "or");
        step(1'b0, 4'b0101, 4'b1010, 3'b100, mk(4'b1111, 0, 0, 0), "xor");
        step(1'b0, 4'b0101, 4'b1010, 3'b101, mk(4'b0000, 0, 1, 0), "nor");

        // Compares.
        step(1'b0, 4'b1111, 4'b0001, 3'b110, mk(4'b0001, 0, 0, 0), "slt");
        step(1'b0, 4'b1111, 4'b0001, 3'b111, mk(4'b0000, 0, 1, 0), "sltu");

        // Reset mid-stream overrides the operation.
        step(1'b1, 4'b0111, 4'b0001, 3'b000, mk(4'b0000, 0, 1, 0), "reset_again");

        // Inputs change every cycle; each result must match the prior cycle's inputs.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic [2:0]   rop;
            ra  = W'($urandom_range(0, 15));
            rb  = W'($urandom_range(0, 15));
            rop = 3'($urandom_range(0, 7));
            step_m(ra, rb, rop, $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
